// File: rtl/button_debounce.sv
// Per-button synchronizer, debouncer and press/release/long-press pulse generator.
// Channels are independent; every output is registered.
module button_debounce #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam int unsigned      DW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned      LW       = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0]    D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0]    L_LAST   = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]    L_MAX    = LW'(LONG_CYCLES);
  localparam logic [N_BTN-1:0] RELEASED = ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_s;

  // Synchronizer resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RELEASED;
      r_sync2 <= RELEASED;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_dcnt;
    logic [DW-1:0]   w_dcnt_nxt;
    logic [LW-1:0]   r_lcnt;
    logic [LW-1:0]   w_lcnt_nxt;
    logic            w_press;
    logic            w_release;
    logic            w_long;
    logic            r_btn_state;
    logic            r_press;
    logic            r_release;
    logic            r_long;

    always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_lcnt_nxt  = r_lcnt;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;

      // Hold timer keeps running through a release bounce; saturation makes the pulse one-shot.
      if ((r_state == PRESSED || r_state == RELEASE_WAIT) && r_lcnt != L_MAX) begin
        w_lcnt_nxt = r_lcnt + 1'b1;
        w_long     = (r_lcnt == L_LAST);
      end

      case (r_state)
        IDLE: begin
          if (w_s[g]) begin
            w_state_nxt = PRESS_WAIT;
            w_dcnt_nxt  = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_s[g]) begin
            w_state_nxt = IDLE;
          end else if (r_dcnt == D_LAST) begin
            w_state_nxt = PRESSED;
            w_press     = 1'b1;
            w_lcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_s[g]) begin
            w_state_nxt = RELEASE_WAIT;
            w_dcnt_nxt  = '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_s[g]) begin
            w_state_nxt = PRESSED;
          end else if (r_dcnt == D_LAST) begin
            w_state_nxt = IDLE;
            w_release   = 1'b1;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state     <= IDLE;
        r_dcnt      <= '0;
        r_lcnt      <= '0;
        r_btn_state <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_dcnt      <= w_dcnt_nxt;
        r_lcnt      <= w_lcnt_nxt;
        r_btn_state <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
        r_press     <= w_press;
        r_release   <= w_release;
        r_long      <= w_long;
      end
    end

    assign btn_state[g]     = r_btn_state;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;
    assign long_pulse[g]    = r_long;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus pushes expected events with their
// edge numbers, a negedge monitor pops them and compares every output each cycle.
module tb_button_debounce;

  localparam int D    = 4;
  localparam int L    = 20;
  localparam int KPR  = 0;
  localparam int KREL = 1;
  localparam int KLNG = 2;

  typedef struct {
    int at;
    int ch;
    int kind;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_state;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] long_pulse;

  int   cyc       = 0;
  int   rst_edge  = -1;
  bit   mon_en    = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  ev_t  sb[$];
  logic [1:0] ep;
  logic [1:0] er;
  logic [1:0] el;
  logic [1:0] exp_state = '0;

  button_debounce #(
    .N_BTN          (2),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_state    (btn_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void expect_ev(input int ch, input int kind, input int at);
    ev_t e;
    e.at   = at;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endfunction

  // Inputs change 2 time units after a posedge, so the next posedge (cyc+1) samples them.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_pin(input int ch, input logic v, output int smp);
    btn_in[ch] = v;
    smp        = cyc + 1;
  endtask

  task automatic pulse_rst();
    int r;
    r        = cyc + 1;
    rst      = 1'b1;
    rst_edge = r;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at >= r) sb.delete(i);
    step(1);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ep = '0;
      er = '0;
      el = '0;
      if (cyc == rst_edge) exp_state = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          case (sb[i].kind)
            KPR:     ep[sb[i].ch] = 1'b1;
            KREL:    er[sb[i].ch] = 1'b1;
            default: el[sb[i].ch] = 1'b1;
          endcase
          sb.delete(i);
        end
      end
      exp_state = (exp_state | ep) & ~er;
      check("press_pulse", 32'(press_pulse), 32'(ep));
      check("release_pulse", 32'(release_pulse), 32'(er));
      check("long_pulse", 32'(long_pulse), 32'(el));
      check("btn_state", 32'(btn_state), 32'(exp_state));
    end
  end

  initial begin
    int e;
    int f;
    int r;
    rst      = 1'b1;
    btn_in   = 2'b11;
    rst_edge = 1;
    step(1);
    mon_en = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);

    // Clean press held 40 cycles, then release.
    set_pin(0, 1'b0, e);
    expect_ev(0, KPR, e + D + 2);
    expect_ev(0, KLNG, e + D + 2 + L);
    step(40);
    set_pin(0, 1'b1, e);
    expect_ev(0, KREL, e + D + 2);
    step(12);

    // Bounce every 2 cycles: no events.
    for (int i = 0; i < 10; i++) begin
      btn_in[0] = ~btn_in[0];
      step(2);
    end
    step(10);

    // Press, then release with a glitch; long press lands inside the final release window.
    set_pin(0, 1'b0, e);
    expect_ev(0, KPR, e + D + 2);
    expect_ev(0, KLNG, e + D + 2 + L);
    step(18);
    set_pin(0, 1'b1, f);
    step(2);
    set_pin(0, 1'b0, f);
    step(1);
    set_pin(0, 1'b1, f);
    expect_ev(0, KREL, f + D + 2);
    step(14);

    // Short press: press and release, no long press.
    set_pin(0, 1'b0, e);
    expect_ev(0, KPR, e + D + 2);
    step(10);
    set_pin(0, 1'b1, e);
    expect_ev(0, KREL, e + D + 2);
    step(12);

    // Both channels pressed together; channel 1 released alone.
    btn_in = 2'b00;
    e      = cyc + 1;
    expect_ev(0, KPR, e + D + 2);
    expect_ev(1, KPR, e + D + 2);
    expect_ev(0, KLNG, e + D + 2 + L);
    step(8);
    set_pin(1, 1'b1, f);
    expect_ev(1, KREL, f + D + 2);
    step(24);

    // Reset while channel 0 is held: fresh press and long press afterwards.
    r = cyc + 1;
    pulse_rst();
    expect_ev(0, KPR, r + D + 3);
    expect_ev(0, KLNG, r + D + 3 + L);
    step(30);
    set_pin(0, 1'b1, e);
    expect_ev(0, KREL, e + D + 2);
    step(12);

    mon_en = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
